irq_arbiter: RTL and testbench

//  Interrupt controller between the board I/O (push-buttons, switches, timer tick)
//  and the RISC core's trap logic.
//  - Synchronises and edge-detects NUM_SRC asynchronous sources and latches them as pending.
//  - Arbitrates enabled pending sources by fixed priority and presents one request+ID to the core.
//  - Sequences the ack/return handshake so only one interrupt is in service at a time.
//  - Enable/pending registers are configured through a small memory-mapped port from the LSU.

---
 rtl/irq_pkg.sv | 24 ++
 rtl/irq_sync_edge.sv | 34 +++
 rtl/irq_arbiter.sv | 144 ++++++++++++++
 tb/tb_irq_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// ---------------------------------------------------------------
// irq_pkg : shared state encoding and register map for irq_arbiter
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;

  localparam int STATUS_BUSY_BIT  = 31;
  localparam int STATUS_STATE_LSB = 8;

endpackage

`default_nettype wire

// File: rtl/irq_sync_edge.sv
// ---------------------------------------------------------------
// irq_sync_edge : multi-stage synchroniser with rising-edge pulse
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_src,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // History resets to 0 so a source held high across reset yields one edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_src};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign o_rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/irq_arbiter.sv
// ---------------------------------------------------------------
// irq_arbiter : edge-latched, fixed-priority interrupt controller
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module irq_arbiter
  import irq_pkg::*;
#(
  parameter int NUM_SRC     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ID_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_SRC-1:0] i_src,
  input  logic               i_mie,
  input  logic               i_irq_ack,
  input  logic               i_mret,
  input  logic               i_cfg_we,
  input  logic [1:0]         i_cfg_addr,
  input  logic [31:0]        i_cfg_wdata,
  output logic [31:0]        o_cfg_rdata,
  output logic               o_irq_req,
  output logic [ID_W-1:0]    o_irq_id,
  output logic               o_busy
);

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] masked, ack_clr, w1c;
  logic [ID_W-1:0]    cand_id, irq_id_q;
  logic               cand_valid, irq_req_q, busy_q;
  irq_state_e         state_q;
  logic               unused_wdata;

  assign unused_wdata = ^i_cfg_wdata;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_src   (i_src[g]),
      .o_rise  (rise[g])
    );
  end

  assign masked     = pending_q & enable_q;
  assign cand_valid = |masked;

  // Descending scan so the lowest set index is the one left standing.
  always_comb begin
    cand_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (masked[i]) cand_id = ID_W'(i);
    end
  end

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ack_clr[i] = (state_q == REQ) && i_irq_ack && (irq_id_q == ID_W'(i));
    end
  end

  assign w1c = (i_cfg_we && (i_cfg_addr == ADDR_PENDING)) ? i_cfg_wdata[NUM_SRC-1:0] : '0;

  // A fresh edge wins over any clear landing on the same bit.
  assign pending_d = (pending_q & ~(ack_clr | w1c)) | rise;
  assign enable_d  = (i_cfg_we && (i_cfg_addr == ADDR_ENABLE)) ? i_cfg_wdata[NUM_SRC-1:0]
                                                                : enable_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      enable_q  <= '0;
      pending_q <= '0;
    end else begin
      enable_q  <= enable_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      irq_id_q  <= '0;
      irq_req_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_mie && cand_valid) begin
            state_q   <= REQ;
            irq_id_q  <= cand_id;
            irq_req_q <= 1'b1;
          end
        end
        REQ: begin
          if (i_irq_ack) begin
            state_q   <= SERVICE;
            irq_req_q <= 1'b0;
            busy_q    <= 1'b1;
          end else if (!i_mie || !pending_q[irq_id_q] || !enable_q[irq_id_q]) begin
            state_q   <= IDLE;
            irq_req_q <= 1'b0;
          end
        end
        SERVICE: begin
          if (i_mret) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          irq_req_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    o_cfg_rdata = '0;
    case (i_cfg_addr)
      ADDR_ENABLE:  o_cfg_rdata[NUM_SRC-1:0] = enable_q;
      ADDR_PENDING: o_cfg_rdata[NUM_SRC-1:0] = pending_q;
      ADDR_STATUS: begin
        o_cfg_rdata[STATUS_BUSY_BIT]            = busy_q;
        o_cfg_rdata[STATUS_STATE_LSB +: 2]      = state_q;
        o_cfg_rdata[ID_W-1:0]                   = irq_id_q;
      end
      default: o_cfg_rdata = '0;
    endcase
  end

  assign o_irq_req = irq_req_q;
  assign o_irq_id  = irq_id_q;
  assign o_busy    = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_irq_arbiter.sv
// ---------------------------------------------------------------
// tb_irq_arbiter : directed bench with cycle model for irq_arbiter
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_irq_arbiter;

  localparam int NUM_SRC = 8;
  localparam int SYNC    = 2;
  localparam int ID_W    = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NUM_SRC-1:0] src = '0;
  logic               mie = 1'b0, ack = 1'b0, mret = 1'b0, we = 1'b0;
  logic [1:0]         addr = 2'd3;
  logic [31:0]        wdata = '0;
  logic [31:0]        rdata;
  logic               irq_req, busy;
  logic [ID_W-1:0]    irq_id;

  int n_chk  = 0;
  int n_fail = 0;

  irq_arbiter #(.NUM_SRC(NUM_SRC), .SYNC_STAGES(SYNC), .ID_W(ID_W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_src       (src),
    .i_mie       (mie),
    .i_irq_ack   (ack),
    .i_mret      (mret),
    .i_cfg_we    (we),
    .i_cfg_addr  (addr),
    .i_cfg_wdata (wdata),
    .o_cfg_rdata (rdata),
    .o_irq_req   (irq_req),
    .o_irq_id    (irq_id),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0=idle, 1=requesting, 2=in service.
  logic [NUM_SRC-1:0] hist [0:SYNC];
  logic [NUM_SRC-1:0] m_pend, m_en;
  int                 m_mode, m_id;
  logic               m_req, m_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= SYNC; k++) hist[k] = '0;
      m_pend = '0; m_en = '0; m_mode = 0; m_id = 0; m_req = 0; m_busy = 0;
    end else begin
      logic [NUM_SRC-1:0] edges, clr, n_en;
      int n_mode, n_id;
      logic n_req, n_busy;
      edges = hist[SYNC-1] & ~hist[SYNC];
      for (int k = SYNC; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = src;
      clr = '0; n_en = m_en;
      n_mode = m_mode; n_id = m_id; n_req = m_req; n_busy = m_busy;
      if (m_mode == 0) begin
        if (mie && ((m_pend & m_en) != 0)) begin
          for (int k = NUM_SRC - 1; k >= 0; k--)
            if (m_pend[k] && m_en[k]) n_id = k;
          n_mode = 1; n_req = 1;
        end
      end else if (m_mode == 1) begin
        if (ack) begin
          clr[m_id] = 1'b1; n_mode = 2; n_req = 0; n_busy = 1;
        end else if (!mie || !m_pend[m_id] || !m_en[m_id]) begin
          n_mode = 0; n_req = 0;
        end
      end else if (mret) begin
        n_mode = 0; n_busy = 0;
      end
      if (we && addr == 2'd0) n_en = wdata[NUM_SRC-1:0];
      if (we && addr == 2'd1) clr = clr | wdata[NUM_SRC-1:0];
      m_pend = (m_pend & ~clr) | edges;
      m_en = n_en; m_mode = n_mode; m_id = n_id; m_req = n_req; m_busy = n_busy;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc_req", irq_req, m_req);
      check("cyc_id", irq_id, m_id);
      check("cyc_busy", busy, m_busy);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    we = 1; addr = a; wdata = d; step(); we = 0; addr = 2'd3; wdata = '0;
  endtask

  task automatic cfg_read(input string name, input logic [1:0] a, input logic [31:0] exp);
    addr = a; #1; check(name, rdata, exp); addr = 2'd3;
  endtask

  task automatic pulse(input int b);
    src[b] = 1'b1; step(); src[b] = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1; step(); ack = 0;
  endtask

  task automatic do_mret();
    mret = 1; step(); mret = 0;
  endtask

  task automatic wait_req(input string name, input int exp_id);
    int n = 0;
    while (!irq_req && n < 20) begin step(); n++; end
    check({name, "_req"}, irq_req, 1);
    check({name, "_id"}, irq_id, exp_id);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #23; rst_n = 1; step();
    check("rst_req", irq_req, 0);
    check("rst_busy", busy, 0);
    check("rst_id", irq_id, 0);
    cfg_read("rst_enable", 2'd0, 32'h0);
    cfg_read("rst_pending", 2'd1, 32'h0);
    cfg_read("rst_status", 2'd2, 32'h0);

    // 1: latency and basic handshake
    cfg_write(2'd0, 32'h01); mie = 1;
    pulse(0); step(); step();
    check("t1_early", irq_req, 0);
    step();
    check("t1_req", irq_req, 1);
    check("t1_id", irq_id, 0);
    check("t1_model_id", m_id, 0);
    do_ack();
    check("t1_ack_busy", busy, 1);
    check("t1_ack_req", irq_req, 0);
    cfg_read("t1_pend", 2'd1, 32'h0);
    cfg_read("t1_status", 2'd2, 32'h8000_0200);
    do_mret();
    check("t1_mret_busy", busy, 0);

    // 2: priority between simultaneous sources
    cfg_write(2'd0, 32'hFF);
    src[3] = 1; src[5] = 1; step(); src = '0;
    wait_req("t2_a", 3);
    cfg_read("t2_pend", 2'd1, 32'h28);
    do_ack(); do_mret();
    wait_req("t2_b", 5);
    do_ack(); do_mret();
    cfg_read("t2_pend_end", 2'd1, 32'h0);

    // 3: no re-arbitration while requesting
    pulse(5);
    wait_req("t3_a", 5);
    pulse(1); repeat (4) step();
    check("t3_hold_id", irq_id, 5);
    check("t3_hold_req", irq_req, 1);
    do_ack(); do_mret();
    wait_req("t3_b", 1);
    do_ack(); do_mret();

    // 4: withdraw via W1C, then via mie
    pulse(2);
    wait_req("t4_a", 2);
    cfg_write(2'd1, 32'h04); step();
    check("t4_w1c_req", irq_req, 0);
    cfg_read("t4_w1c_status", 2'd2, 32'h2);
    pulse(2);
    wait_req("t4_b", 2);
    mie = 0; step();
    check("t4_mie_req", irq_req, 0);
    cfg_read("t4_mie_pend", 2'd1, 32'h04);
    cfg_read("t4_mie_status", 2'd2, 32'h2);
    cfg_write(2'd1, 32'h04); mie = 1; step();

    // 5: new edge coincides with ack clear
    pulse(4);
    wait_req("t5_a", 4);
    src[4] = 1; step(); step();
    ack = 1; step(); ack = 0; src[4] = 0;
    check("t5_busy", busy, 1);
    cfg_read("t5_pend", 2'd1, 32'h10);
    do_mret();
    wait_req("t5_b", 4);
    do_ack(); do_mret();

    // 6: asynchronous reset in service, source held across reset
    pulse(6);
    wait_req("t6_a", 6);
    do_ack();
    src[7] = 1; step();
    check("t6_pre_busy", busy, 1);
    #2 rst_n = 0; #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_req", irq_req, 0);
    cfg_read("t6_rst_en", 2'd0, 32'h0);
    cfg_read("t6_rst_pend", 2'd1, 32'h0);
    repeat (3) step();
    rst_n = 1; step();
    cfg_write(2'd0, 32'hFF); mie = 1;
    wait_req("t6_b", 7);
    do_ack(); do_mret();
    repeat (10) step();
    check("t6_once", irq_req, 0);
    src = '0; step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
